// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32IM+Zicsr+Zicond instruction word assembler with LI expansion
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err
);

    // Mnemonic codes
    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd1;
    localparam logic [5:0] OP_AND    = 6'd2;
    localparam logic [5:0] OP_OR     = 6'd3;
    localparam logic [5:0] OP_XOR    = 6'd4;
    localparam logic [5:0] OP_SLL    = 6'd5;
    localparam logic [5:0] OP_SRL    = 6'd6;
    localparam logic [5:0] OP_SRA    = 6'd7;
    localparam logic [5:0] OP_SLT    = 6'd8;
    localparam logic [5:0] OP_SLTU   = 6'd9;
    localparam logic [5:0] OP_ADDI   = 6'd10;
    localparam logic [5:0] OP_ANDI   = 6'd11;
    localparam logic [5:0] OP_ORI    = 6'd12;
    localparam logic [5:0] OP_XORI   = 6'd13;
    localparam logic [5:0] OP_SLLI   = 6'd14;
    localparam logic [5:0] OP_SRLI   = 6'd15;
    localparam logic [5:0] OP_SRAI   = 6'd16;
    localparam logic [5:0] OP_SLTI   = 6'd17;
    localparam logic [5:0] OP_SLTIU  = 6'd18;
    localparam logic [5:0] OP_LB     = 6'd19;
    localparam logic [5:0] OP_LH     = 6'd20;
    localparam logic [5:0] OP_LW     = 6'd21;
    localparam logic [5:0] OP_LBU    = 6'd22;
    localparam logic [5:0] OP_LHU    = 6'd23;
    localparam logic [5:0] OP_SB     = 6'd24;
    localparam logic [5:0] OP_SH     = 6'd25;
    localparam logic [5:0] OP_SW     = 6'd26;
    localparam logic [5:0] OP_BEQ    = 6'd27;
    localparam logic [5:0] OP_BNE    = 6'd28;
    localparam logic [5:0] OP_BLT    = 6'd29;
    localparam logic [5:0] OP_BGE    = 6'd30;
    localparam logic [5:0] OP_BLTU   = 6'd31;
    localparam logic [5:0] OP_BGEU   = 6'd32;
    localparam logic [5:0] OP_JAL    = 6'd33;
    localparam logic [5:0] OP_JALR   = 6'd34;
    localparam logic [5:0] OP_LUI    = 6'd35;
    localparam logic [5:0] OP_AUIPC  = 6'd36;
    localparam logic [5:0] OP_CSRRW  = 6'd37;
    localparam logic [5:0] OP_CSRRS  = 6'd38;
    localparam logic [5:0] OP_CSRRC  = 6'd39;
    localparam logic [5:0] OP_CSRRWI = 6'd40;
    localparam logic [5:0] OP_CSRRSI = 6'd41;
    localparam logic [5:0] OP_CSRRCI = 6'd42;
    localparam logic [5:0] OP_ECALL  = 6'd43;
    localparam logic [5:0] OP_MRET   = 6'd44;
    localparam logic [5:0] OP_SRET   = 6'd45;
    localparam logic [5:0] OP_MUL    = 6'd46;
    localparam logic [5:0] OP_MULH   = 6'd47;
    localparam logic [5:0] OP_MULHSU = 6'd48;
    localparam logic [5:0] OP_MULHU  = 6'd49;
    localparam logic [5:0] OP_DIV    = 6'd50;
    localparam logic [5:0] OP_DIVU   = 6'd51;
    localparam logic [5:0] OP_REM    = 6'd52;
    localparam logic [5:0] OP_REMU   = 6'd53;
    localparam logic [5:0] OP_CZEQZ  = 6'd54;
    localparam logic [5:0] OP_CZNEZ  = 6'd55;
    localparam logic [5:0] OP_LI     = 6'd56;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;
    localparam logic [6:0] F7_CZ   = 7'b0000111;

    typedef enum logic {IDLE, LI_LO} state_t;

    state_t      state, state_nxt;
    logic        acc;
    logic        slot_free;
    logic        emit_lo;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        enc_two;
    logic [4:0]  lo_rd;
    logic [11:0] lo_imm;
    logic [19:0] li_hi;
    logic        imm_ok_i;
    logic        imm_ok_sh;
    logic        imm_ok_b;
    logic        imm_ok_j;

    function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] fmt_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] fmt_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] fmt_b(input logic [12:1] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] fmt_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] fmt_j(input logic [20:1] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
    endfunction

    // Immediate range qualifiers: sign bits above the field must all agree
    assign imm_ok_i  = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign imm_ok_sh = ~(|req_imm[31:5]);
    assign imm_ok_b  = ~req_imm[0] & ((&req_imm[31:12]) | ~(|req_imm[31:12]));
    assign imm_ok_j  = ~req_imm[0] & ((&req_imm[31:20]) | ~(|req_imm[31:20]));

    // LI upper part rounds so the sign-extended low 12 bits land back on imm
    assign li_hi = req_imm[31:12] + {19'd0, req_imm[11]};

    // Encode the presented request into its first (or only) word
    always_comb begin
        enc_inst = 32'h0000_0000;
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        case (req_op)
            OP_ADD:    enc_inst = fmt_r(F7_BASE, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP);
            OP_SUB:    enc_inst = fmt_r(F7_ALT,  req_rs2, req_rs1, 3'b000, req_rd, OPC_OP);
            OP_SLL:    enc_inst = fmt_r(F7_BASE, req_rs2, req_rs1, 3'b001, req_rd, OPC_OP);
            OP_SLT:    enc_inst = fmt_r(F7_BASE, req_rs2, req_rs1, 3'b010, req_rd, OPC_OP);
            OP_SLTU:   enc_inst = fmt_r(F7_BASE, req_rs2, req_rs1, 3'b011, req_rd, OPC_OP);
            OP_XOR:    enc_inst = fmt_r(F7_BASE, req_rs2, req_rs1, 3'b100, req_rd, OPC_OP);
            OP_SRL:    enc_inst = fmt_r(F7_BASE, req_rs2, req_rs1, 3'b101, req_rd, OPC_OP);
            OP_SRA:    enc_inst = fmt_r(F7_ALT,  req_rs2, req_rs1, 3'b101, req_rd, OPC_OP);
            OP_OR:     enc_inst = fmt_r(F7_BASE, req_rs2, req_rs1, 3'b110, req_rd, OPC_OP);
            OP_AND:    enc_inst = fmt_r(F7_BASE, req_rs2, req_rs1, 3'b111, req_rd, OPC_OP);
            OP_MUL:    enc_inst = fmt_r(F7_MULD, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP);
            OP_MULH:   enc_inst = fmt_r(F7_MULD, req_rs2, req_rs1, 3'b001, req_rd, OPC_OP);
            OP_MULHSU: enc_inst = fmt_r(F7_MULD, req_rs2, req_rs1, 3'b010, req_rd, OPC_OP);
            OP_MULHU:  enc_inst = fmt_r(F7_MULD, req_rs2, req_rs1, 3'b011, req_rd, OPC_OP);
            OP_DIV:    enc_inst = fmt_r(F7_MULD, req_rs2, req_rs1, 3'b100, req_rd, OPC_OP);
            OP_DIVU:   enc_inst = fmt_r(F7_MULD, req_rs2, req_rs1, 3'b101, req_rd, OPC_OP);
            OP_REM:    enc_inst = fmt_r(F7_MULD, req_rs2, req_rs1, 3'b110, req_rd, OPC_OP);
            OP_REMU:   enc_inst = fmt_r(F7_MULD, req_rs2, req_rs1, 3'b111, req_rd, OPC_OP);
            OP_CZEQZ:  enc_inst = fmt_r(F7_CZ,   req_rs2, req_rs1, 3'b101, req_rd, OPC_OP);
            OP_CZNEZ:  enc_inst = fmt_r(F7_CZ,   req_rs2, req_rs1, 3'b111, req_rd, OPC_OP);
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
                if (imm_ok_i) begin
                    case (req_op)
                        OP_SLTI:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_OPIMM);
                        OP_SLTIU: enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b011, req_rd, OPC_OPIMM);
                        OP_XORI:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b100, req_rd, OPC_OPIMM);
                        OP_ORI:   enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b110, req_rd, OPC_OPIMM);
                        OP_ANDI:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b111, req_rd, OPC_OPIMM);
                        default:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_OPIMM);
                    endcase
                end else begin
                    enc_err = 1'b1;
                end
            end
            OP_SLLI, OP_SRLI, OP_SRAI: begin
                if (imm_ok_sh) begin
                    case (req_op)
                        OP_SLLI: enc_inst = fmt_i({F7_BASE, req_imm[4:0]}, req_rs1, 3'b001, req_rd, OPC_OPIMM);
                        OP_SRLI: enc_inst = fmt_i({F7_BASE, req_imm[4:0]}, req_rs1, 3'b101, req_rd, OPC_OPIMM);
                        default: enc_inst = fmt_i({F7_ALT,  req_imm[4:0]}, req_rs1, 3'b101, req_rd, OPC_OPIMM);
                    endcase
                end else begin
                    enc_err = 1'b1;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_JALR: begin
                if (imm_ok_i) begin
                    case (req_op)
                        OP_LB:   enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_LOAD);
                        OP_LH:   enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b001, req_rd, OPC_LOAD);
                        OP_LW:   enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_LOAD);
                        OP_LBU:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b100, req_rd, OPC_LOAD);
                        OP_LHU:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b101, req_rd, OPC_LOAD);
                        default: enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR);
                    endcase
                end else begin
                    enc_err = 1'b1;
                end
            end
            OP_SB, OP_SH, OP_SW: begin
                if (imm_ok_i) begin
                    case (req_op)
                        OP_SB:   enc_inst = fmt_s(req_imm[11:0], req_rs2, req_rs1, 3'b000);
                        OP_SH:   enc_inst = fmt_s(req_imm[11:0], req_rs2, req_rs1, 3'b001);
                        default: enc_inst = fmt_s(req_imm[11:0], req_rs2, req_rs1, 3'b010);
                    endcase
                end else begin
                    enc_err = 1'b1;
                end
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                if (imm_ok_b) begin
                    case (req_op)
                        OP_BEQ:  enc_inst = fmt_b(req_imm[12:1], req_rs2, req_rs1, 3'b000);
                        OP_BNE:  enc_inst = fmt_b(req_imm[12:1], req_rs2, req_rs1, 3'b001);
                        OP_BLT:  enc_inst = fmt_b(req_imm[12:1], req_rs2, req_rs1, 3'b100);
                        OP_BGE:  enc_inst = fmt_b(req_imm[12:1], req_rs2, req_rs1, 3'b101);
                        OP_BLTU: enc_inst = fmt_b(req_imm[12:1], req_rs2, req_rs1, 3'b110);
                        default: enc_inst = fmt_b(req_imm[12:1], req_rs2, req_rs1, 3'b111);
                    endcase
                end else begin
                    enc_err = 1'b1;
                end
            end
            OP_JAL: begin
                if (imm_ok_j) enc_inst = fmt_j(req_imm[20:1], req_rd);
                else          enc_err  = 1'b1;
            end
            OP_LUI:    enc_inst = fmt_u(req_imm[31:12], req_rd, OPC_LUI);
            OP_AUIPC:  enc_inst = fmt_u(req_imm[31:12], req_rd, OPC_AUIPC);
            OP_CSRRW:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b001, req_rd, OPC_SYSTEM);
            OP_CSRRS:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_SYSTEM);
            OP_CSRRC:  enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b011, req_rd, OPC_SYSTEM);
            OP_CSRRWI: enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b101, req_rd, OPC_SYSTEM);
            OP_CSRRSI: enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b110, req_rd, OPC_SYSTEM);
            OP_CSRRCI: enc_inst = fmt_i(req_imm[11:0], req_rs1, 3'b111, req_rd, OPC_SYSTEM);
            OP_ECALL:  enc_inst = 32'h0000_0073;
            OP_MRET:   enc_inst = 32'h3020_0073;
            OP_SRET:   enc_inst = 32'h1020_0073;
            OP_LI: begin
                if (req_rd == 5'd0) begin
                    // Writes to x0 are discarded anyway; emit a canonical NOP
                    enc_inst = fmt_i(12'h000, 5'd0, 3'b000, 5'd0, OPC_OPIMM);
                end else if (imm_ok_i) begin
                    enc_inst = fmt_i(req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OPIMM);
                end else begin
                    enc_inst = fmt_u(li_hi, req_rd, OPC_LUI);
                    enc_two  = (req_imm[11:0] != 12'h000);
                end
            end
            default:   enc_err = 1'b1;
        endcase
        if (enc_err) enc_inst = 32'h0000_0000;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: LI_LO lasts until the ADDI half gets the output slot
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc && enc_two) state_nxt = LI_LO;
            LI_LO:   if (slot_free)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake and second-word emit strobe
    always_comb begin
        slot_free = !out_valid || out_ready;
        req_ready = (state == IDLE) && slot_free;
        emit_lo   = (state == LI_LO) && slot_free;
    end

    assign acc = req_valid && req_ready;

    // Capture the LI low half while its LUI is being emitted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_rd  <= 5'd0;
            lo_imm <= 12'h000;
        end else if (acc && enc_two) begin
            lo_rd  <= req_rd;
            lo_imm <= req_imm[11:0];
        end
    end

    // Output register: reloads on the same edge it drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= 32'h0000_0000;
            out_err   <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_inst  <= enc_inst;
            out_err   <= enc_err;
        end else if (emit_lo) begin
            out_valid <= 1'b1;
            out_inst  <= fmt_i(lo_imm, lo_rd, 3'b000, lo_rd, OPC_OPIMM);
            out_err   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder
module tb_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    typedef struct {
        string       tag;
        logic [32:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   bp_en       = 0;

    inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Random output back-pressure when enabled
    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard monitor: a transfer is visible mid-cycle before the edge that takes it
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val(e.tag, {31'd0, out_err, out_inst}, {31'd0, e.word});
            end
        end
    end

    task automatic expect_word(input string tag, input logic err, input logic [31:0] inst);
        exp_t e;
        e.tag  = tag;
        e.word = {err, inst};
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) check_val("accept_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic vec(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic err, input logic [31:0] inst);
        expect_word($sformatf("op%0d_imm%0h", op, imm), err, inst);
        drive(op, rd, rs1, rs2, imm);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 6'd0;
        req_rd    = 5'd0;
        req_rs1   = 5'd0;
        req_rs2   = 5'd0;
        req_imm   = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_inst",  64'(out_inst),  64'd0);
        check_val("rst_out_err",   64'(out_err),   64'd0);
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with one-cycle latency
        vec(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3);
        check_val("add_latency", 64'(out_valid), 64'd1);
        drain();

        // LI split into LUI + ADDI, request side stalled in between
        expect_word("li_lui",  1'b0, 32'h1234_52B7);
        expect_word("li_addi", 1'b0, 32'h6782_8293);
        drive(6'd56, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        check_val("li_ready_low", 64'(req_ready), 64'd0);
        drain();
        expect_word("li_fff_lui",  1'b0, 32'h0000_10B7);
        expect_word("li_fff_addi", 1'b0, 32'hFFF0_8093);
        drive(6'd56, 5'd1, 5'd0, 5'd0, 32'h0000_0FFF);
        drain();

        // MRET held under back-pressure
        out_ready = 1'b0;
        expect_word("mret", 1'b0, 32'h3020_0073);
        drive(6'd44, 5'd3, 5'd4, 5'd5, 32'h0000_0123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_inst",  64'(out_inst),  64'h3020_0073);
            check_val("hold_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back ADDI at full throughput
        for (int i = 0; i < 4; i++) expect_word("b2b_addi", 1'b0, 32'h0050_0093);
        t0 = cyc;
        for (int i = 0; i < 4; i++) drive(6'd10, 5'd1, 5'd0, 5'd0, 32'd5);
        check_val("b2b_cycles", 64'(cyc - t0), 64'd4);
        drain();

        // Encoding table under random back-pressure
        bp_en = 1;
        vec(6'd1,  5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 32'h4020_81B3);
        vec(6'd16, 5'd1, 5'd2, 5'd0, 32'd3,        1'b0, 32'h4031_5093);
        vec(6'd14, 5'd1, 5'd2, 5'd0, 32'd32,       1'b1, 32'h0000_0000);
        vec(6'd10, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b1, 32'h0000_0000);
        vec(6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0, 32'h8000_0093);
        vec(6'd26, 5'd0, 5'd2, 5'd3, 32'd8,        1'b0, 32'h0031_2423);
        vec(6'd27, 5'd0, 5'd1, 5'd2, 32'd8,        1'b0, 32'h0020_8463);
        vec(6'd27, 5'd0, 5'd1, 5'd2, 32'd7,        1'b1, 32'h0000_0000);
        vec(6'd28, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000, 1'b0, 32'h8000_1063);
        vec(6'd28, 5'd0, 5'd0, 5'd0, 32'd4096,     1'b1, 32'h0000_0000);
        vec(6'd33, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b0, 32'h0010_00EF);
        vec(6'd33, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 1'b1, 32'h0000_0000);
        vec(6'd34, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFC1_00E7);
        vec(6'd22, 5'd1, 5'd2, 5'd0, 32'd4,        1'b0, 32'h0041_4083);
        vec(6'd35, 5'd2, 5'd7, 5'd9, 32'hABCD_E123, 1'b0, 32'hABCD_E137);
        vec(6'd36, 5'd1, 5'd0, 5'd0, 32'h0000_1FFF, 1'b0, 32'h0000_1097);
        vec(6'd38, 5'd5, 5'd0, 5'd0, 32'h0000_0300, 1'b0, 32'h3000_22F3);
        vec(6'd40, 5'd0, 5'd3, 5'd0, 32'h0000_0305, 1'b0, 32'h3051_D073);
        vec(6'd43, 5'd7, 5'd8, 5'd9, 32'h0000_0123, 1'b0, 32'h0000_0073);
        vec(6'd45, 5'd7, 5'd8, 5'd9, 32'h0000_0000, 1'b0, 32'h1020_0073);
        vec(6'd46, 5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 32'h0220_81B3);
        vec(6'd51, 5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 32'h0220_D1B3);
        vec(6'd54, 5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 32'h0E20_D1B3);
        vec(6'd60, 5'd3, 5'd1, 5'd2, 32'd0,        1'b1, 32'h0000_0000);
        vec(6'd56, 5'd4, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0213);
        vec(6'd56, 5'd6, 5'd0, 5'd0, 32'h0001_0000, 1'b0, 32'h0001_0337);
        vec(6'd56, 5'd0, 5'd0, 5'd0, 32'h1234_5678, 1'b0, 32'h0000_0013);
        expect_word("bp_li_lui",  1'b0, 32'h1234_52B7);
        expect_word("bp_li_addi", 1'b0, 32'h6782_8293);
        drive(6'd56, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        vec(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3);
        drain();
        bp_en = 0;
        out_ready = 1'b0;
        drain();

        // Reset during LI_LO drops the second word
        drive(6'd56, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        check_val("midli_ready_low", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_val("midli_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("midli_no_addi", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        vec(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
